sevenseg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the Nexys A7 8-digit common-anode 7-segment display.
- Holds a frame-coherent hex value, digit-enable mask and decimal-point mask.
- Sequences the anodes with a programmable dwell time and an inter-digit blanking gap, and drives decoded segment lines.
- Sits in the SweRVolf Nexys top level on clk_core and is fed from GPIO or debug counters, replacing the free-running one-cycle anode rotation.

---
 rtl/sevenseg_scan_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// sevenseg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display (Nexys A7).
// A hex value, digit-enable mask and decimal-point mask are captured into pending registers on
// i_load and promoted to the active set only at the frame wrap, so a frame is never torn.
// Each slot is a BLANK gap (all anodes off) followed by a DRIVE dwell on one anode. Disabled
// digits still consume their slot, so the frame period is constant.
//
// Ports:
//   clk           clock
//   rstn          synchronous active-low reset
//   i_value       hex value, nibble k drives digit k (k=0 rightmost)
//   i_digit_en    per-digit enable, 1=lit
//   i_dp          per-digit decimal point, 1=on
//   i_load        one-cycle strobe capturing value/en/dp into the pending registers
//   i_blank       global blank, forces all anodes off (registered, one cycle latency)
//   o_an          anodes, active-low
//   o_seg         segments, active-low, bit6=a .. bit0=g
//   o_dp          decimal point, active-low
//   o_digit_idx   index of the current slot
//   o_frame_done  one-cycle pulse on the first cycle after slot NUM_DIGITS-1 ends
// ---------------------------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_digit_en,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_load,
    input  logic                      i_blank,
    output logic [NUM_DIGITS-1:0]     o_an,
    output logic [6:0]                o_seg,
    output logic                      o_dp,
    output logic [2:0]                o_digit_idx,
    output logic                      o_frame_done
);

    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                     : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
    // With no gap the BLANK state is only ever entered out of reset; leave it after one cycle.
    localparam logic [CntW-1:0] BlankLast = (BLANK_CYCLES == 0) ? '0 : CntW'(BLANK_CYCLES - 1);
    localparam logic [2:0]      IdxLast   = 3'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    // Active-low abcdefg decode of one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Scan state
    state_e                    st_q, st_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic                      wrap;

    // Frame data: active set is displayed, pending set waits for the wrap
    logic [4*NUM_DIGITS-1:0]   act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]     act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0]   pen_val_q, pen_val_d;
    logic [NUM_DIGITS-1:0]     pen_en_q, pen_en_d;
    logic [NUM_DIGITS-1:0]     pen_dp_q, pen_dp_d;
    logic                      pend_q, pend_d;

    // Output registers
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      fd_q, fd_d;

    logic [3:0]                sel_nib;
    logic                      sel_dp;

    // Next-state: slot sequencing
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        wrap  = 1'b0;
        fd_d  = 1'b0;
        unique case (st_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    st_d  = StDrive;
                    cnt_d = '0;
                end
            end
            StDrive: begin
                if (cnt_q == DwellLast) begin
                    cnt_d = '0;
                    st_d  = (BLANK_CYCLES == 0) ? StDrive : StBlank;
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                        fd_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                st_d  = StBlank;
                cnt_d = '0;
            end
        endcase
    end

    // Next-state: frame-coherent data. A load on the wrap edge bypasses pending entirely.
    always_comb begin
        act_val_d = act_val_q;
        act_en_d  = act_en_q;
        act_dp_d  = act_dp_q;
        pen_val_d = pen_val_q;
        pen_en_d  = pen_en_q;
        pen_dp_d  = pen_dp_q;
        pend_d    = pend_q;
        if (wrap) begin
            if (i_load) begin
                act_val_d = i_value;
                act_en_d  = i_digit_en;
                act_dp_d  = i_dp;
            end else if (pend_q) begin
                act_val_d = pen_val_q;
                act_en_d  = pen_en_q;
                act_dp_d  = pen_dp_q;
            end
            pend_d = 1'b0;
        end else if (i_load) begin
            pen_val_d = i_value;
            pen_en_d  = i_digit_en;
            pen_dp_d  = i_dp;
            pend_d    = 1'b1;
        end
    end

    // Outputs are computed from the state being entered so they change on the same edge.
    always_comb begin
        sel_nib = '0;
        sel_dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == 3'(k)) begin
                sel_nib = act_val_d[4*k +: 4];
                sel_dp  = act_dp_d[k];
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !((st_d == StDrive) && (idx_d == 3'(k)) && act_en_d[k] && !i_blank);
        end
        if (st_d == StDrive) begin
            seg_d = decode(sel_nib);
            dp_d  = ~sel_dp;
        end else begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q      <= StBlank;
            cnt_q     <= '0;
            idx_q     <= '0;
            act_val_q <= '0;
            act_en_q  <= '0;
            act_dp_q  <= '0;
            pen_val_q <= '0;
            pen_en_q  <= '0;
            pen_dp_q  <= '0;
            pend_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            act_val_q <= act_val_d;
            act_en_q  <= act_en_d;
            act_dp_q  <= act_dp_d;
            pen_val_q <= pen_val_d;
            pen_en_q  <= pen_en_d;
            pen_dp_q  <= pen_dp_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign o_an         = an_q;
    assign o_seg        = seg_q;
    assign o_dp         = dp_q;
    assign o_digit_idx  = idx_q;
    assign o_frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with NUM_DIGITS=8, DWELL_CYCLES=4, BLANK_CYCLES=2.
// The reference tracks the position inside a 48-cycle frame and derives every output from it.
module tb_sevenseg_scan_ctrl;

    localparam int NDig  = 8;
    localparam int Dwell = 4;
    localparam int Blank = 2;
    localparam int Slot  = Dwell + Blank;
    localparam int Frame = NDig * Slot;

    logic            clk;
    logic            rstn;
    logic [31:0]     val;
    logic [7:0]      en;
    logic [7:0]      dp;
    logic            ld;
    logic            blk;
    logic [7:0]      o_an;
    logic [6:0]      o_seg;
    logic            o_dp;
    logic [2:0]      o_digit_idx;
    logic            o_frame_done;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (NDig),
        .DWELL_CYCLES(Dwell),
        .BLANK_CYCLES(Blank)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_value     (val),
        .i_digit_en  (en),
        .i_dp        (dp),
        .i_load      (ld),
        .i_blank     (blk),
        .o_an        (o_an),
        .o_seg       (o_seg),
        .o_dp        (o_dp),
        .o_digit_idx (o_digit_idx),
        .o_frame_done(o_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-low abcdefg patterns for hex digits 0..F
    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state
    int          m_p;
    logic        m_fd;
    logic        m_blk;
    logic [31:0] m_av, m_pv;
    logic [7:0]  m_ae, m_pe, m_ad, m_pd;
    logic        m_pen;

    task automatic model_edge();
        if (!rstn) begin
            m_p   = 0;
            m_fd  = 1'b0;
            m_blk = 1'b0;
            m_av  = '0; m_ae = '0; m_ad = '0;
            m_pv  = '0; m_pe = '0; m_pd = '0;
            m_pen = 1'b0;
        end else begin
            m_p   = (m_p + 1) % Frame;
            m_fd  = (m_p == 0);
            m_blk = blk;
            if (m_p == 0) begin
                if (ld) begin
                    m_av = val; m_ae = en; m_ad = dp;
                end else if (m_pen) begin
                    m_av = m_pv; m_ae = m_pe; m_ad = m_pd;
                end
                m_pen = 1'b0;
            end else if (ld) begin
                m_pv = val; m_pe = en; m_pd = dp;
                m_pen = 1'b1;
            end
        end
    endtask

    task automatic check();
        int         slot;
        bit         drv;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [2:0] exp_idx;
        logic [3:0] nib;
        slot    = m_p / Slot;
        drv     = (m_p % Slot) >= Blank;
        nib     = m_av[4*slot +: 4];
        exp_an  = 8'hFF;
        if (drv && m_ae[slot] && !m_blk) exp_an[slot] = 1'b0;
        exp_seg = drv ? seg_tab[nib] : 7'h7F;
        exp_dp  = drv ? ~m_ad[slot] : 1'b1;
        exp_idx = 3'(slot);

        vectors++;
        assert (o_an === exp_an) else begin
            miscompares++;
            $error("FAIL an pos=%0d got=%h exp=%h", m_p, o_an, exp_an);
        end
        vectors++;
        assert (o_seg === exp_seg) else begin
            miscompares++;
            $error("FAIL seg pos=%0d got=%h exp=%h", m_p, o_seg, exp_seg);
        end
        vectors++;
        assert (o_dp === exp_dp) else begin
            miscompares++;
            $error("FAIL dp pos=%0d got=%b exp=%b", m_p, o_dp, exp_dp);
        end
        vectors++;
        assert (o_digit_idx === exp_idx) else begin
            miscompares++;
            $error("FAIL idx pos=%0d got=%0d exp=%0d", m_p, o_digit_idx, exp_idx);
        end
        vectors++;
        assert (o_frame_done === m_fd) else begin
            miscompares++;
            $error("FAIL frame_done pos=%0d got=%b exp=%b", m_p, o_frame_done, m_fd);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1 check();
    endtask

    // Advance until the current frame position equals target (at most one frame).
    task automatic wait_pos(input int target);
        for (int i = 0; i < Frame + 1 && m_p != target; i++) cyc();
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
        val = v; en = e; dp = d; ld = 1'b1;
        cyc();
        ld = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ld = 1'b0; blk = 1'b0; val = '0; en = '0; dp = '0;
        m_p = 0;
        cyc();
        cyc();
        rstn = 1'b1;

        // Idle scan: inputs wiggle but nothing is loaded, display stays dark
        repeat (100) begin
            val = $urandom; en = 8'($urandom); dp = 8'($urandom);
            cyc();
        end

        // Full count-up pattern, then one whole frame
        load(32'h76543210, 8'hFF, 8'h01);
        repeat (60) cyc();

        // Mid-frame load during slot 3 must wait for the wrap
        wait_pos(3 * Slot + Blank);
        load(32'hFFFFFFFF, 8'hFF, 8'h00);
        repeat (60) cyc();

        // Sparse enable mask; slot timing stays fixed
        load($urandom, 8'b10100101, 8'($urandom));
        repeat (60) cyc();

        // Global blank during DRIVE of slot 2
        wait_pos(2 * Slot + Blank + 1);
        blk = 1'b1;
        repeat (10) cyc();
        blk = 1'b0;
        repeat (10) cyc();

        // Two loads in one frame: last one wins
        wait_pos(Slot);
        load(32'h01234567, 8'hFF, 8'hAA);
        repeat (5) cyc();
        load(32'h89ABCDEF, 8'hFF, 8'h55);
        repeat (50) cyc();

        // Load on the exact wrap edge goes straight to active
        wait_pos(Frame - 1);
        load($urandom, 8'hFF, 8'($urandom));
        repeat (50) cyc();

        // Randomized traffic
        repeat (400) begin
            ld  = ($urandom_range(0, 7) == 0);
            blk = ($urandom_range(0, 9) == 0);
            val = $urandom; en = 8'($urandom); dp = 8'($urandom);
            cyc();
        end
        ld = 1'b0; blk = 1'b0;

        // Reset mid-DRIVE of slot 5 with a load pending: display must go dark
        wait_pos(0);
        load($urandom, 8'hFF, 8'hFF);
        wait_pos(5 * Slot + Blank + 1);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        repeat (60) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
